// File: rtl/cv32e40p_rf_err_monitor.sv
// -----------------------------------------------------------------------------
// cv32e40p_rf_err_monitor
//
// Watches the register-file ECC check outputs of the core wrapper. Each of the
// three ports has a saturating single-error counter and a sticky double-error
// (DED) flag. A three-state health FSM (OK / WARN / FATAL) drives a level
// interrupt and, optionally, a debug halt request. Software reads and clears
// the counters and flags through a small req/gnt/rvalid register port.
//
// The FSM state is observable through STATUS[1:0].
//
// Register port handshake: a request is granted in the same cycle it is
// raised (reg_gnt_o == reg_req_i). Every granted request, read or write,
// gets exactly one reg_rvalid_o pulse on the following cycle. reg_rdata_o
// carries read data only during that pulse and is zero otherwise, including
// for write responses. A read issued in the same cycle as an update returns
// the value from before that update.
//
// Register map (word-aligned, addr[1:0] ignored):
//   0x00 STATUS  RO  [1:0] state, [4:2] ded flags, [5] irq enable
//   0x04 SE_CNT0 RO
//   0x08 SE_CNT1 RO
//   0x0C SE_CNT2 RO
//   0x10 CTRL    W   bit0 clear counters, bit1 clear DED flags,
//                    bit2 irq enable (reads back in bit2)
//   others       read 0, writes ignored
//
// Build option:
//   CV32E40P_RF_ERR_HALT_EN  when defined, debug_req_o is a registered level
//                            that is high while the FSM is in FATAL. When
//                            undefined, debug_req_o is tied to 0.
//
// Parameters:
//   CNT_W      width of each single-error counter (2..32)
//   SE_THRESH  counter value at or above which WARN is entered
//
// Ports:
//   clk_i         core clock
//   rst_i         synchronous active-high reset
//   single_err_i  per-port single-error event, one event per high cycle
//   ded_i         per-port double-error event, one event per high cycle
//   reg_req_i     register access request
//   reg_gnt_o     grant (same cycle as request)
//   reg_we_i      1 = write
//   reg_addr_i    byte address
//   reg_wdata_i   write data
//   reg_rvalid_o  response valid, one cycle after grant
//   reg_rdata_o   read data
//   err_irq_o     level interrupt to the core
//   debug_req_o   halt request to the core
// -----------------------------------------------------------------------------
module cv32e40p_rf_err_monitor #(
  parameter int CNT_W     = 16,
  parameter int SE_THRESH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  single_err_i,
  input  logic [2:0]  ded_i,
  input  logic        reg_req_i,
  output logic        reg_gnt_o,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_rvalid_o,
  output logic [31:0] reg_rdata_o,
  output logic        err_irq_o,
  output logic        debug_req_o
);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_FATAL = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(SE_THRESH);

  localparam logic [2:0] IDX_STATUS = 3'd0;
  localparam logic [2:0] IDX_CNT0   = 3'd1;
  localparam logic [2:0] IDX_CNT1   = 3'd2;
  localparam logic [2:0] IDX_CNT2   = 3'd3;
  localparam logic [2:0] IDX_CTRL   = 3'd4;

  // State
  state_e           state_q, state_d;
  logic [CNT_W-1:0] se_cnt_q [3];
  logic [CNT_W-1:0] se_cnt_d [3];
  logic [2:0]       ded_q, ded_d;
  logic             irq_en_q, irq_en_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;

  // Register port decode
  logic [2:0]  reg_idx;
  logic        wr_ctrl;
  logic        clr_cnt;
  logic        clr_ded;
  logic        rd_en;
  logic [31:0] rdata_mux;
  logic        any_hi;
  logic        any_ded;

  // Address low bits and undefined CTRL bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:3]};

  assign reg_idx   = reg_addr_i[4:2];
  assign reg_gnt_o = reg_req_i;
  assign wr_ctrl   = reg_req_i & reg_we_i & (reg_idx == IDX_CTRL);
  assign clr_cnt   = wr_ctrl & reg_wdata_i[0];
  assign clr_ded   = wr_ctrl & reg_wdata_i[1];
  assign rd_en     = reg_req_i & ~reg_we_i;

  // Counters: a clear in the same cycle as an event leaves the counter at 1,
  // because the clear is applied before that cycle's event.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      se_cnt_d[k] = clr_cnt ? '0 : se_cnt_q[k];
      if (single_err_i[k] && (se_cnt_d[k] != CNT_MAX)) begin
        se_cnt_d[k] = se_cnt_d[k] + CNT_ONE;
      end
    end
  end

  // DED flags: a new event wins over a clear in the same cycle.
  assign ded_d    = (clr_ded ? 3'b000 : ded_q) | ded_i;
  assign irq_en_d = wr_ctrl ? reg_wdata_i[2] : irq_en_q;

  // Health decisions are taken on post-update values.
  always_comb begin
    any_hi = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (se_cnt_d[k] >= THRESH) begin
        any_hi = 1'b1;
      end
    end
  end

  assign any_ded = |ded_d;

  // Health FSM next state. Counters only decrease through a clear and DED
  // flags only drop through a clear, so leaving WARN or FATAL here always
  // corresponds to a software clear.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OK: begin
        if (any_ded)     state_d = ST_FATAL;
        else if (any_hi) state_d = ST_WARN;
        else             state_d = ST_OK;
      end
      ST_WARN: begin
        if (any_ded)     state_d = ST_FATAL;
        else if (any_hi) state_d = ST_WARN;
        else             state_d = ST_OK;
      end
      ST_FATAL: begin
        if (any_ded)     state_d = ST_FATAL;
        else if (any_hi) state_d = ST_WARN;
        else             state_d = ST_OK;
      end
      default: begin
        state_d = ST_OK;
      end
    endcase
  end

  // Read mux uses the pre-update (registered) values.
  always_comb begin
    rdata_mux = '0;
    unique case (reg_idx)
      IDX_STATUS: rdata_mux = {26'd0, irq_en_q, ded_q, state_q};
      IDX_CNT0:   rdata_mux = 32'(se_cnt_q[0]);
      IDX_CNT1:   rdata_mux = 32'(se_cnt_q[1]);
      IDX_CNT2:   rdata_mux = 32'(se_cnt_q[2]);
      IDX_CTRL:   rdata_mux = {29'd0, irq_en_q, 2'b00};
      default:    rdata_mux = '0;
    endcase
  end

  assign rvalid_d = reg_req_i;
  assign rdata_d  = rd_en ? rdata_mux : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_OK;
      ded_q    <= 3'b000;
      irq_en_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int k = 0; k < 3; k++) begin
        se_cnt_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ded_q    <= ded_d;
      irq_en_q <= irq_en_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      for (int k = 0; k < 3; k++) begin
        se_cnt_q[k] <= se_cnt_d[k];
      end
    end
  end

  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign err_irq_o    = irq_en_q & (state_q != ST_OK);

`ifdef CV32E40P_RF_ERR_HALT_EN
  // Registered from the next state so the halt level tracks state_q exactly.
  logic halt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= (state_d == ST_FATAL);
    end
  end

  assign debug_req_o = halt_q;
`else
  assign debug_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_rf_err_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for cv32e40p_rf_err_monitor (CNT_W=4, SE_THRESH=8).
// Directed steps followed by random traffic, all compared against a
// behavioural model: counters are plain integers clamped at 2^CNT_W-1, the
// health state is derived from the rule "any DED flag -> FATAL, else any
// counter >= threshold -> WARN, else OK".
// -----------------------------------------------------------------------------
module tb_cv32e40p_rf_err_monitor;

  localparam int CNT_W     = 4;
  localparam int SE_THRESH = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst_i;
  logic [2:0]  single_err_i;
  logic [2:0]  ded_i;
  logic        reg_req_i;
  logic        reg_gnt_o;
  logic        reg_we_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_rvalid_o;
  logic [31:0] reg_rdata_o;
  logic        err_irq_o;
  logic        debug_req_o;

  cv32e40p_rf_err_monitor #(
    .CNT_W     (CNT_W),
    .SE_THRESH (SE_THRESH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .single_err_i (single_err_i),
    .ded_i        (ded_i),
    .reg_req_i    (reg_req_i),
    .reg_gnt_o    (reg_gnt_o),
    .reg_we_i     (reg_we_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_rvalid_o (reg_rvalid_o),
    .reg_rdata_o  (reg_rdata_o),
    .err_irq_o    (err_irq_o),
    .debug_req_o  (debug_req_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model
  int       m_cnt [3];
  bit [2:0] m_ded;
  bit       m_irq_en;

  function automatic int m_state();
    if (m_ded != 3'b000) return 2;
    for (int k = 0; k < 3; k++) begin
      if (m_cnt[k] >= SE_THRESH) return 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    logic [31:0] v;
    v = 32'd0;
    case (addr[4:2])
      3'd0: v = 32'(m_state()) | (32'(m_ded) << 2) | (32'(m_irq_en) << 5);
      3'd1: v = 32'(m_cnt[0]);
      3'd2: v = 32'(m_cnt[1]);
      3'd3: v = 32'(m_cnt[2]);
      3'd4: v = 32'(m_irq_en) << 2;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after a rising edge.
  task automatic step(input bit rst, input bit [2:0] se, input bit [2:0] dd,
                      input bit req, input bit we, input bit [4:0] addr,
                      input bit [31:0] wdata);
    logic [31:0] exp_rd;
    bit          exp_v;
    bit          ctrl;
    bit          exp_dbg;
    rst_i        = rst;
    single_err_i = se;
    ded_i        = dd;
    reg_req_i    = req;
    reg_we_i     = we;
    reg_addr_i   = addr;
    reg_wdata_i  = wdata;
    #1;
    chk("gnt", {31'd0, reg_gnt_o}, {31'd0, req});
    exp_rd = 32'd0;
    exp_v  = 1'b0;
    if (rst) begin
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      m_ded    = 3'b000;
      m_irq_en = 1'b0;
    end else begin
      exp_v = req;
      if (req && !we) exp_rd = m_read(addr);
      ctrl = req && we && (addr[4:2] == 3'd4);
      for (int k = 0; k < 3; k++) begin
        if (ctrl && wdata[0]) m_cnt[k] = 0;
        if (se[k] && m_cnt[k] < CNT_MAX) m_cnt[k] = m_cnt[k] + 1;
      end
      if (ctrl && wdata[1]) m_ded = 3'b000;
      m_ded = m_ded | dd;
      if (ctrl) m_irq_en = wdata[2];
    end
    @(posedge clk);
    #1;
`ifdef CV32E40P_RF_ERR_HALT_EN
    exp_dbg = (m_state() == 2);
`else
    exp_dbg = 1'b0;
`endif
    chk("rvalid", {31'd0, reg_rvalid_o}, {31'd0, exp_v});
    chk("rdata", reg_rdata_o, exp_rd);
    chk("irq", {31'd0, err_irq_o}, {31'd0, (m_irq_en && m_state() != 0)});
    chk("debug_req", {31'd0, debug_req_o}, {31'd0, exp_dbg});
  endtask

  task automatic rd(input bit [4:0] addr);
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, addr, 32'd0);
  endtask

  task automatic wr(input bit [4:0] addr, input bit [31:0] d);
    step(1'b0, 3'b000, 3'b000, 1'b1, 1'b1, addr, d);
  endtask

  task automatic idle(input bit [2:0] se, input bit [2:0] dd);
    step(1'b0, se, dd, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    bit [2:0] r_se;
    bit [2:0] r_dd;
    rst_i        = 1'b1;
    single_err_i = 3'b000;
    ded_i        = 3'b000;
    reg_req_i    = 1'b0;
    reg_we_i     = 1'b0;
    reg_addr_i   = 5'd0;
    reg_wdata_i  = 32'd0;

    // Reset state
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0);
    rd(5'h00);
    rd(5'h04);
    rd(5'h08);
    rd(5'h0C);

    // Threshold crossing on port 1
    wr(5'h10, 32'h4);
    repeat (8) idle(3'b010, 3'b000);
    chk("irq_after_8", {31'd0, err_irq_o}, 32'd1);
    rd(5'h08);
    chk("se_cnt1_eq_8", reg_rdata_o, 32'd8);
    rd(5'h00);
    chk("status_warn", reg_rdata_o, 32'h21);
    wr(5'h10, 32'h5);
    chk("irq_cleared", {31'd0, err_irq_o}, 32'd0);
    rd(5'h00);
    rd(5'h10);

    // Saturation at 2^CNT_W-1
    repeat (20) idle(3'b001, 3'b000);
    rd(5'h04);
    chk("se_cnt0_sat", reg_rdata_o, 32'd15);

    // DED handling
    wr(5'h10, 32'h1);
    idle(3'b000, 3'b100);
    rd(5'h00);
    chk("status_fatal", reg_rdata_o, 32'h12);
    step(1'b0, 3'b000, 3'b100, 1'b1, 1'b1, 5'h10, 32'h2);
    rd(5'h00);
    chk("status_still_fatal", reg_rdata_o, 32'h12);
    wr(5'h10, 32'h2);
    rd(5'h00);
    chk("status_ok", reg_rdata_o, 32'h0);

    // Counter clear with simultaneous error
    step(1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 5'h10, 32'h1);
    rd(5'h04);
    chk("clr_plus_event", reg_rdata_o, 32'd1);

    // Unmapped and RO writes
    wr(5'h04, 32'hFFFF_FFFF);
    rd(5'h14);
    rd(5'h1C);
    rd(5'h07);

    // Reset during an in-flight read
    wr(5'h10, 32'h4);
    repeat (8) idle(3'b100, 3'b000);
    step(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 5'h0C, 32'd0);
    chk("rvalid_aborted", {31'd0, reg_rvalid_o}, 32'd0);
    idle(3'b000, 3'b000);
    rd(5'h00);
    rd(5'h0C);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 3; k++) begin
        r_se[k] = ($urandom_range(0, 3) == 0);
        r_dd[k] = ($urandom_range(0, 59) == 0);
      end
      step(1'b0, r_se, r_dd, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0) ? $urandom : (32'h4 & $urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
